// File: rtl/stream_pkg.sv
// rtl/stream_pkg.sv - shared constants and state encoding for the two-input stream arbiter
package stream_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_grant2.sv
// rtl/rr_grant2.sv - two-way round-robin grant with packet lock and idle hold
module rr_grant2 (
  input  logic [1:0] valid,
  input  logic       last_served,
  input  logic       lock,
  input  logic       lock_id,
  input  logic       prev_grant,
  output logic       grant
);

  // Locked: stay on the owner. Unlocked: sole requester wins, ties go to the
  // channel not served last, and with no requester the grant does not move.
  always_comb begin
    grant = prev_grant;
    if (lock) begin
      grant = lock_id;
    end else begin
      case (valid)
        2'b01:   grant = 1'b0;
        2'b10:   grant = 1'b1;
        2'b11:   grant = ~last_served;
        default: grant = prev_grant;
      endcase
    end
  end

endmodule

// File: rtl/stream_arb2.sv
// rtl/stream_arb2.sv - packet-atomic round-robin merge of two valid/ready streams
module stream_arb2
  import stream_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in0_valid,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_last,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_last,
  output logic             in1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             sel,
  output logic             busy
);

  arb_state_t       state_q;
  arb_state_t       state_d;
  logic             grant;
  logic             grant_q;
  logic             last_served_q;
  logic             space;
  logic             accept;
  logic             lock;
  logic             lock_id;
  logic [WIDTH-1:0] mux_data;
  logic             mux_last;
  logic             mux_valid;

  assign lock    = (state_q != ST_IDLE);
  assign lock_id = (state_q == ST_LOCK1);

  rr_grant2 u_grant (
    .valid       ({in1_valid, in0_valid}),
    .last_served (last_served_q),
    .lock        (lock),
    .lock_id     (lock_id),
    .prev_grant  (grant_q),
    .grant       (grant)
  );

  // 2:1 select of the granted channel's beat.
  assign mux_data  = grant ? in1_data  : in0_data;
  assign mux_last  = grant ? in1_last  : in0_last;
  assign mux_valid = grant ? in1_valid : in0_valid;

  // The output register can take a beat when empty or draining this cycle.
  assign space  = !out_valid || out_ready;
  assign accept = mux_valid && space;

  // All registers: state, output beat, grant memory and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_last      <= 1'b0;
      grant_q       <= 1'b0;
      last_served_q <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant;
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= mux_data;
        out_last  <= mux_last;
        if (mux_last) begin
          last_served_q <= grant;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Lock on the first non-final beat of a packet, release on its final beat.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      if (mux_last) begin
        state_d = ST_IDLE;
      end else begin
        state_d = grant ? ST_LOCK1 : ST_LOCK0;
      end
    end
  end

  // Handshake and status outputs; only the granted channel ever sees ready.
  always_comb begin
    in0_ready = (grant == 1'b0) && space;
    in1_ready = (grant == 1'b1) && space;
    sel       = grant;
    busy      = lock;
  end

endmodule

// File: tb/tb_stream_arb2.sv
// tb/tb_stream_arb2.sv - self-checking bench for stream_arb2 with a reference model
module tb_stream_arb2;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in0_valid, in0_last, in0_ready;
  logic [W-1:0] in0_data;
  logic         in1_valid, in1_last, in1_ready;
  logic [W-1:0] in1_data;
  logic         out_valid, out_last, out_ready;
  logic [W-1:0] out_data;
  logic         sel, busy;

  int errors = 0;
  int checks = 0;

  stream_arb2 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in0_valid (in0_valid),
    .in0_data  (in0_data),
    .in0_last  (in0_last),
    .in0_ready (in0_ready),
    .in1_valid (in1_valid),
    .in1_data  (in1_data),
    .in1_last  (in1_last),
    .in1_ready (in1_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .sel       (sel),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: packet owner (-1 when free), round-robin memory,
  // remembered grant and the single-entry output buffer.
  int           m_owner = -1;
  bit           m_ls = 1'b1;
  bit           m_gprev = 1'b0;
  bit           m_ov = 1'b0;
  bit           m_ol = 1'b0;
  logic [W-1:0] m_od = '0;
  bit           m_init = 1'b0;

  function automatic bit m_grant();
    if (m_owner >= 0) return (m_owner == 1);
    if (in0_valid && !in1_valid) return 1'b0;
    if (in1_valid && !in0_valid) return 1'b1;
    if (in0_valid && in1_valid) return !m_ls;
    return m_gprev;
  endfunction

  function automatic bit m_space();
    return !m_ov || out_ready;
  endfunction

  always begin
    @(posedge clk);
    if (!rst_n) begin
      m_owner = -1;
      m_ls    = 1'b1;
      m_gprev = 1'b0;
      m_ov    = 1'b0;
      m_ol    = 1'b0;
      m_od    = '0;
      m_init  = 1'b1;
    end else if (m_init) begin
      automatic bit g   = m_grant();
      automatic bit v   = g ? in1_valid : in0_valid;
      automatic bit lst = g ? in1_last : in0_last;
      if (v && m_space()) begin
        m_ov = 1'b1;
        m_od = g ? in1_data : in0_data;
        m_ol = lst;
        if (lst) begin
          m_owner = -1;
          m_ls    = g;
        end else begin
          m_owner = g ? 1 : 0;
        end
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
      m_gprev = g;
    end
  end

  always begin
    @(posedge clk);
    #3;
    if (m_init) begin
      automatic bit g = m_grant();
      chk("m_out_valid", 32'(out_valid), 32'(m_ov));
      if (m_ov) begin
        chk("m_out_data", 32'(out_data), 32'(m_od));
        chk("m_out_last", 32'(out_last), 32'(m_ol));
      end
      chk("m_in0_ready", 32'(in0_ready), 32'(!g && m_space()));
      chk("m_in1_ready", 32'(in1_ready), 32'(g && m_space()));
      chk("m_sel", 32'(sel), 32'(g));
      chk("m_busy", 32'(busy), 32'(m_owner >= 0));
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    in0_valid = 1'b0; in0_data = '0; in0_last = 1'b0;
    in1_valid = 1'b0; in1_data = '0; in1_last = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_in0_ready", 32'(in0_ready), 32'd1);
    chk("rst_in1_ready", 32'(in1_ready), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // single beat, latency one
    rst_n = 1'b1;
    in0_valid = 1'b1; in0_data = 8'h11; in0_last = 1'b1; out_ready = 1'b1;
    tick();
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_data", 32'(out_data), 32'h11);
    chk("single_last", 32'(out_last), 32'd1);
    chk("single_busy", 32'(busy), 32'd0);
    in0_valid = 1'b0;

    // alternating single-beat packets, channel 0 first after reset
    reset_pulse();
    in0_valid = 1'b1; in0_last = 1'b1;
    in1_valid = 1'b1; in1_last = 1'b1;
    for (int i = 0; i < 4; i++) begin
      automatic logic [W-1:0] exp_d = (i % 2 == 0) ? W'(8'hA0 + i / 2) : W'(8'hB0 + i / 2);
      in0_data = W'(8'hA0 + (i + 1) / 2);
      in1_data = W'(8'hB0 + i / 2);
      tick();
      chk("alt_valid", 32'(out_valid), 32'd1);
      chk("alt_data", 32'(out_data), 32'(exp_d));
    end

    // three-beat packet on channel 0 holds channel 1 off
    in0_data = 8'h01; in0_last = 1'b0;
    in1_data = 8'hFF; in1_last = 1'b1;
    #1;
    chk("pkt_in1_ready_0", 32'(in1_ready), 32'd0);
    tick();
    chk("pkt_data_1", 32'(out_data), 32'h01);
    chk("pkt_busy_1", 32'(busy), 32'd1);
    in0_data = 8'h02;
    #1;
    chk("pkt_in1_ready_1", 32'(in1_ready), 32'd0);
    tick();
    chk("pkt_data_2", 32'(out_data), 32'h02);
    chk("pkt_busy_2", 32'(busy), 32'd1);
    in0_data = 8'h03; in0_last = 1'b1;
    #1;
    chk("pkt_in1_ready_2", 32'(in1_ready), 32'd0);
    tick();
    chk("pkt_data_3", 32'(out_data), 32'h03);
    chk("pkt_busy_3", 32'(busy), 32'd0);
    in0_valid = 1'b0;
    tick();
    chk("pkt_data_ff", 32'(out_data), 32'hFF);
    chk("pkt_last_ff", 32'(out_last), 32'd1);

    // backpressure stall and simultaneous drain/accept
    in1_valid = 1'b0;
    in0_valid = 1'b1; in0_data = 8'h55; in0_last = 1'b1;
    tick();
    chk("stall_first", 32'(out_data), 32'h55);
    out_ready = 1'b0; in0_data = 8'h66;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_in0_ready", 32'(in0_ready), 32'd0);
      chk("stall_in1_ready", 32'(in1_ready), 32'd0);
      tick();
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", 32'(out_data), 32'h55);
    end
    out_ready = 1'b1;
    tick();
    chk("drain_next_valid", 32'(out_valid), 32'd1);
    chk("drain_next_data", 32'(out_data), 32'h66);
    in0_valid = 1'b0;
    tick();
    chk("drain_empty", 32'(out_valid), 32'd0);

    // reset in the middle of a channel 1 packet
    in1_valid = 1'b1; in1_last = 1'b0; in1_data = 8'hC1;
    tick();
    in1_data = 8'hC2;
    tick();
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_data", 32'(out_data), 32'hC2);
    rst_n = 1'b0; in1_valid = 1'b0;
    tick();
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_sel", 32'(sel), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    in0_valid = 1'b1; in0_last = 1'b1; in0_data = 8'hD0;
    in1_valid = 1'b1; in1_last = 1'b1; in1_data = 8'hE0;
    #1;
    chk("post_rst_sel", 32'(sel), 32'd0);
    tick();
    chk("post_rst_d0", 32'(out_data), 32'hD0);
    tick();
    chk("post_rst_e0", 32'(out_data), 32'hE0);

    // randomized traffic, including occasional resets and valid drops
    repeat (3000) begin
      rst_n     = ($urandom_range(0, 299) != 0);
      in0_valid = ($urandom_range(0, 2) != 0);
      in1_valid = ($urandom_range(0, 2) != 0);
      in0_data  = W'($urandom);
      in1_data  = W'($urandom);
      in0_last  = ($urandom_range(0, 2) == 0);
      in1_last  = ($urandom_range(0, 2) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
